// File: rtl/home_inventory_sample_sequencer_pkg.sv
// Shared definitions for the home-inventory sample sequencer.
//   seq_state_t : frame FSM state encoding
//   CH_IDX_W    : width of the ADC channel index
//   SAMPLE_W    : width of one conversion result / timestamp
//   sat_inc     : saturating increment used by the event counters
package home_inventory_sample_sequencer_pkg;

   localparam int CH_IDX_W = 3;
   localparam int SAMPLE_W = 32;
   localparam int MAX_CH   = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT   = 2'd2,
      ST_COMMIT = 2'd3
   } seq_state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/home_inventory_period_timer.sv
// Frame period timer. Counts 0..period-1 while enabled and raises tick on
// the last count, then reloads to 0. Held at 0 when enable=0 or period=0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          run the timer
//   period[31:0]    frame period in clk cycles (0 = halted)
//   tick            combinational one-cycle frame-start strobe
module home_inventory_period_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] period,
   output logic        tick
);

   logic [31:0] cnt;
   logic        run;

   assign run = enable && (period != 32'd0);
   // >= rather than == so a period shortened mid-count still wraps promptly
   // instead of running the counter all the way around.
   assign tick = run && (cnt >= period - 32'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 32'd0;
      end else if (!run || tick) begin
         cnt <= 32'd0;
      end else begin
         cnt <= cnt + 32'd1;
      end
   end

endmodule

// File: rtl/home_inventory_sample_sequencer.sv
// Periodic / triggered ADC frame sequencer. Each frame requests NUM_CH
// conversions in order, gathers the results into shadows and commits them
// together with the frame-start timestamp in one sample_valid pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable, period[31:0]     periodic sampling control (period 0 = halted)
//   soft_trig                single-frame request
//   adc_req, adc_ch[2:0]     conversion request / channel
//   adc_ack, adc_data[31:0]  conversion done / result
//   sample_valid             frame commit strobe
//   ts_now[31:0]             timestamp of committed frame
//   sample_ch0..7[31:0]      committed samples
//   busy                     frame in progress
//   overrun_count[31:0]      starts dropped while busy (saturating)
//   timeout_count[31:0]      channels abandoned on timeout (saturating)
//
// state  | meaning
// IDLE   | waiting for tick or soft_trig
// REQ    | adc_req pulse for current channel, timeout counter cleared
// WAIT   | waiting for adc_ack or timeout on current channel
// COMMIT | shadows copied to outputs, sample_valid pulsed
module home_inventory_sample_sequencer
   import home_inventory_sample_sequencer_pkg::*;
#(
   parameter int          NUM_CH      = 8,
   parameter int          ACK_TIMEOUT = 64,
   parameter logic [31:0] TS_INIT     = 32'h0   // ts_ctr reset value
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [31:0]         period,
   input  logic                soft_trig,
   output logic                adc_req,
   output logic [CH_IDX_W-1:0] adc_ch,
   input  logic                adc_ack,
   input  logic [SAMPLE_W-1:0] adc_data,
   output logic                sample_valid,
   output logic [31:0]         ts_now,
   output logic [SAMPLE_W-1:0] sample_ch0,
   output logic [SAMPLE_W-1:0] sample_ch1,
   output logic [SAMPLE_W-1:0] sample_ch2,
   output logic [SAMPLE_W-1:0] sample_ch3,
   output logic [SAMPLE_W-1:0] sample_ch4,
   output logic [SAMPLE_W-1:0] sample_ch5,
   output logic [SAMPLE_W-1:0] sample_ch6,
   output logic [SAMPLE_W-1:0] sample_ch7,
   output logic                busy,
   output logic [31:0]         overrun_count,
   output logic [31:0]         timeout_count
);

   localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(NUM_CH - 1);
   localparam logic [15:0]         TMO_LAST = 16'(ACK_TIMEOUT - 1);

   seq_state_t          state;
   logic [31:0]         ts_ctr;
   logic [31:0]         ts_shadow;
   logic [CH_IDX_W-1:0] idx;
   logic [15:0]         tmo_ctr;
   logic [SAMPLE_W-1:0] shadow [MAX_CH];
   logic [SAMPLE_W-1:0] samp   [MAX_CH];
   logic                tick;
   logic                start;

   home_inventory_period_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .enable (enable),
      .period (period),
      .tick   (tick)
   );

   assign start = tick | soft_trig;

   assign sample_ch0 = samp[0];
   assign sample_ch1 = samp[1];
   assign sample_ch2 = samp[2];
   assign sample_ch3 = samp[3];
   assign sample_ch4 = samp[4];
   assign sample_ch5 = samp[5];
   assign sample_ch6 = samp[6];
   assign sample_ch7 = samp[7];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         ts_ctr        <= TS_INIT;
         ts_shadow     <= 32'd0;
         idx           <= '0;
         tmo_ctr       <= 16'd0;
         adc_req       <= 1'b0;
         adc_ch        <= '0;
         sample_valid  <= 1'b0;
         busy          <= 1'b0;
         ts_now        <= 32'd0;
         overrun_count <= 32'd0;
         timeout_count <= 32'd0;
         for (int i = 0; i < MAX_CH; i++) begin
            shadow[i] <= '0;
            samp[i]   <= '0;
         end
      end else begin
         ts_ctr       <= ts_ctr + 32'd1;
         adc_req      <= 1'b0;
         sample_valid <= 1'b0;

         // COMMIT counts as busy, so a start there is also an overrun.
         if (start && state != ST_IDLE) begin
            overrun_count <= sat_inc(overrun_count);
         end

         case (state)
            ST_IDLE: begin
               if (start) begin
                  ts_shadow <= ts_ctr;
                  idx       <= '0;
                  adc_ch    <= '0;
                  adc_req   <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               tmo_ctr <= 16'd0;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               // An ack on the final timeout cycle still wins over the timeout.
               if (adc_ack || tmo_ctr == TMO_LAST) begin
                  shadow[idx] <= adc_ack ? adc_data : '0;
                  if (!adc_ack) begin
                     timeout_count <= sat_inc(timeout_count);
                  end
                  if (idx == LAST_CH) begin
                     state <= ST_COMMIT;
                  end else begin
                     idx     <= idx + 1'b1;
                     adc_ch  <= idx + 1'b1;
                     adc_req <= 1'b1;
                     state   <= ST_REQ;
                  end
               end else begin
                  tmo_ctr <= tmo_ctr + 16'd1;
               end
            end
            ST_COMMIT: begin
               sample_valid <= 1'b1;
               ts_now       <= ts_shadow;
               for (int i = 0; i < MAX_CH; i++) begin
                  samp[i] <= (i < NUM_CH) ? shadow[i] : '0;
               end
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_home_inventory_sample_sequencer.sv
// Scoreboard bench for home_inventory_sample_sequencer: stimulus pushes the
// expected committed frame (commit cycle, timestamp, 8 samples); a monitor
// pops and compares on every sample_valid. An ADC responder acks requests
// after a configurable delay and can leave one channel unanswered.
module tb_home_inventory_sample_sequencer;

   localparam logic [31:0] TS_INIT = 32'hFFFF_FFF0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] period = 32'd0;
   logic        soft_trig = 1'b0;
   logic        adc_req;
   logic [2:0]  adc_ch;
   wire logic   adc_ack;
   wire logic [31:0] adc_data;
   logic        sample_valid;
   logic [31:0] ts_now;
   logic [31:0] sample_ch0, sample_ch1, sample_ch2, sample_ch3;
   logic [31:0] sample_ch4, sample_ch5, sample_ch6, sample_ch7;
   logic        busy;
   logic [31:0] overrun_count, timeout_count;

   logic [31:0] samp [8];
   assign samp[0] = sample_ch0;
   assign samp[1] = sample_ch1;
   assign samp[2] = sample_ch2;
   assign samp[3] = sample_ch3;
   assign samp[4] = sample_ch4;
   assign samp[5] = sample_ch5;
   assign samp[6] = sample_ch6;
   assign samp[7] = sample_ch7;

   logic        resp_ack = 1'b0;
   logic [31:0] resp_data = 32'd0;
   logic        man_ack = 1'b0;
   logic [31:0] man_data = 32'd0;
   assign adc_ack  = resp_ack | man_ack;
   assign adc_data = man_ack ? man_data : resp_data;

   always #5 clk = ~clk;

   home_inventory_sample_sequencer #(
      .NUM_CH      (8),
      .ACK_TIMEOUT (64),
      .TS_INIT     (TS_INIT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .period        (period),
      .soft_trig     (soft_trig),
      .adc_req       (adc_req),
      .adc_ch        (adc_ch),
      .adc_ack       (adc_ack),
      .adc_data      (adc_data),
      .sample_valid  (sample_valid),
      .ts_now        (ts_now),
      .sample_ch0    (sample_ch0),
      .sample_ch1    (sample_ch1),
      .sample_ch2    (sample_ch2),
      .sample_ch3    (sample_ch3),
      .sample_ch4    (sample_ch4),
      .sample_ch5    (sample_ch5),
      .sample_ch6    (sample_ch6),
      .sample_ch7    (sample_ch7),
      .busy          (busy),
      .overrun_count (overrun_count),
      .timeout_count (timeout_count)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference cycle counter and timestamp model.
   int          cyc = 0;
   logic [31:0] ts_m;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) ts_m <= TS_INIT;
      else     ts_m <= ts_m + 32'd1;
   end

   typedef struct {
      int               vcyc;
      logic [31:0]      ts;
      logic [7:0][31:0] d;
   } frame_t;

   frame_t sb[$];

   int          resp_delay = 1;
   int          resp_skip  = -1;
   logic [31:0] data_base  = 32'd0;
   logic [2:0]  resp_ch;

   function automatic frame_t mk(input int vcyc, input logic [31:0] ts, input int skip);
      frame_t f;
      f.vcyc = vcyc;
      f.ts   = ts;
      for (int i = 0; i < 8; i++)
         f.d[i] = (i == skip) ? 32'd0 : data_base + 32'(i * 16);
      return f;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ADC responder
   initial begin
      @(posedge clk);
      #1;
      forever begin
         if (adc_req) begin
            if (int'(adc_ch) == resp_skip) begin
               step(1);
            end else begin
               resp_ch = adc_ch;
               step(resp_delay);
               resp_ack  = 1'b1;
               resp_data = data_base + 32'(resp_ch) * 32'd16;
               step(1);
               resp_ack  = 1'b0;
            end
         end else begin
            step(1);
         end
      end
   end

   // Monitor
   initial begin
      frame_t f;
      forever begin
         @(posedge clk);
         #1;
         if (sample_valid) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_sample_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
               f = sb.pop_front();
               check32("commit_cycle", 32'(cyc), 32'(f.vcyc));
               check32("ts_now", ts_now, f.ts);
               for (int i = 0; i < 8; i++)
                  check32($sformatf("sample_ch%0d", i), samp[i], f.d[i]);
            end
         end
      end
   end

   task automatic wait_drain(input int max, input string name);
      int n = 0;
      while (sb.size() != 0 && n < max) begin
         step(1);
         n++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: got %0d frames pending after %0d cycles expected 0", name, sb.size(), max);
         sb.delete();
      end
   endtask

   task automatic soft_frame(input int lat, input int skip);
      sb.push_back(mk(cyc + lat, ts_m, skip));
      soft_trig = 1'b1;
      step(1);
      soft_trig = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check32({tag, "_adc_req"}, 32'(adc_req), 32'd0);
      check32({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
      check32({tag, "_busy"}, 32'(busy), 32'd0);
      check32({tag, "_ts_now"}, ts_now, 32'd0);
      check32({tag, "_overrun"}, overrun_count, 32'd0);
      check32({tag, "_timeout"}, timeout_count, 32'd0);
      for (int i = 0; i < 8; i++)
         check32($sformatf("%s_sample_ch%0d", tag, i), samp[i], 32'd0);
   endtask

   initial begin
      int a_cyc;
      logic [31:0] a_ts;
      int n;

      // reset
      step(3);
      rst = 1'b0;
      step(1);
      check_all_zero("reset");

      // soft trigger, ts_ctr wrapping between two commits
      data_base = 32'd0;
      soft_frame(18, -1);
      wait_drain(100, "soft_frame1");
      check32("soft_ch3", sample_ch3, 32'h30);
      step(4);
      check32("hold_ch3", sample_ch3, 32'h30);
      data_base = 32'h1000;
      soft_frame(18, -1);
      wait_drain(100, "soft_frame2_wrapped");

      // periodic, period 100, ack one cycle after request
      data_base = 32'h2000;
      period    = 32'd100;
      enable    = 1'b1;
      a_cyc     = cyc;
      a_ts      = ts_m;
      for (int k = 0; k < 3; k++)
         sb.push_back(mk(a_cyc + 99 + 100 * k + 18, a_ts + 32'(99 + 100 * k), -1));
      step(300);
      enable = 1'b0;          // last frame is still in flight here
      wait_drain(100, "periodic100");
      check32("periodic_overrun", overrun_count, 32'd0);

      // channel 5 never acked
      data_base = 32'h3000;
      resp_skip = 5;
      soft_frame(18 + 63, -1);
      sb[sb.size() - 1] = mk(sb[sb.size() - 1].vcyc, sb[sb.size() - 1].ts, 5);
      step(4);
      check32("busy_mid_frame", 32'(busy), 32'd1);
      wait_drain(200, "timeout_frame");
      resp_skip = -1;
      check32("timeout_count", timeout_count, 32'd1);

      // period 10 with slow acks: frames every 50 cycles, 4 dropped ticks each
      data_base  = 32'h4000;
      resp_delay = 5;
      period     = 32'd10;
      enable     = 1'b1;
      a_cyc      = cyc;
      a_ts       = ts_m;
      for (int k = 0; k < 3; k++)
         sb.push_back(mk(a_cyc + 9 + 50 * k + 50, a_ts + 32'(9 + 50 * k), -1));
      step(9);
      soft_trig = 1'b1;       // coincides with the first tick
      step(1);
      soft_trig = 1'b0;
      step(100);
      enable = 1'b0;
      wait_drain(200, "overrun_frames");
      check32("overrun_count", overrun_count, 32'd8);
      check32("timeout_after_overrun", timeout_count, 32'd1);
      resp_delay = 1;

      // reset while waiting on channel 4, then a late ack
      data_base = 32'h5000;
      resp_skip = 4;
      soft_trig = 1'b1;
      step(1);
      soft_trig = 1'b0;
      n = 0;
      while (!(adc_req && adc_ch == 3'd4) && n < 100) begin
         step(1);
         n++;
      end
      if (n >= 100) begin
         n_cmp++;
         n_err++;
         $display("FAIL reach_ch4: got no request for ch4 expected one within 100 cycles");
      end
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      man_ack  = 1'b1;
      man_data = 32'hDEAD_BEEF;
      step(1);
      man_ack = 1'b0;
      step(30);
      check_all_zero("post_rst");
      resp_skip = -1;

      // sequencer recovers after reset
      data_base = 32'h6000;
      soft_frame(18, -1);
      wait_drain(100, "post_rst_frame");
      check32("post_rst_overrun", overrun_count, 32'd0);

      step(5);
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL leftover_frames: got %0d expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: got no completion expected finish before 500000");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1);
   end

endmodule
